// File: rtl/serial_adder.sv
// Digit-serial ripple adder/subtractor: DIGIT bits per clock, LSB first.
// start/busy/done handshake, registered carry, signed overflow flag.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_v;
  logic             r_busy;
  logic             r_done;

  logic [DIGIT:0]   w_dsum;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_s_next;

  assign w_dsum = {1'b0, r_a[DIGIT-1:0]}
                + {1'b0, r_b[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_c};
  // carry into the top bit of this digit, recovered from its sum bit
  assign w_cmsb = w_dsum[DIGIT-1]
                ^ r_a[DIGIT-1]
                ^ r_b[DIGIT-1];
  assign w_last = (r_cnt == CW'(STEPS - 1));

  generate
    if (STEPS > 1) begin : g_shift
      assign w_s_next = {w_dsum[DIGIT-1:0],
                         r_s[WIDTH-1:DIGIT]};
    end else begin : g_whole
      assign w_s_next = w_dsum[DIGIT-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_a     <= A;
            r_b     <= B ^ {WIDTH{SUB}};
            r_c     <= Ci;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_c   <= w_dsum[DIGIT];
          r_s   <= w_s_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= IDLE;
            r_co    <= w_dsum[DIGIT];
            r_v     <= w_cmsb ^ w_dsum[DIGIT];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign S    = r_s;
  assign Co   = r_co;
  assign V    = r_v;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8-bit/1-digit vector table and corner
// sequences, plus exhaustive 4-bit/2-digit back-to-back run.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 8-bit, 1 bit per cycle
  logic       rst8, st8, sub8, ci8;
  logic [7:0] a8, b8, s8;
  logic       co8, v8, busy8, done8;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst8), .start(st8), .SUB(sub8),
    .A(a8), .B(b8), .Ci(ci8),
    .S(s8), .Co(co8), .V(v8),
    .busy(busy8), .done(done8)
  );

  // 4-bit, 2 bits per cycle
  logic       rst4, st4, sub4, ci4;
  logic [3:0] a4, b4, s4;
  logic       co4, v4, busy4, done4;

  serial_adder #(.WIDTH(4), .DIGIT(2)) u4 (
    .clk(clk), .rst(rst4), .start(st4), .SUB(sub4),
    .A(a4), .B(b4), .Ci(ci4),
    .S(s4), .Co(co4), .V(v4),
    .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       v;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // counts edges after the accept edge until done (bounded)
  task automatic wait_done8(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done8 && n < 40);
  endtask

  // start an op on u8 and scramble inputs while it runs
  task automatic run8(input vec_t t, input string nm);
    int n;
    a8 = t.a; b8 = t.b; ci8 = t.ci; sub8 = t.sub;
    st8 = 1'b1;
    step();
    st8 = 1'b0;
    check({nm, "_busy"}, {31'd0, busy8}, 32'd1);
    a8 = ~t.a; b8 = t.b + 8'h5A;
    ci8 = ~t.ci; sub8 = ~t.sub;
    wait_done8(n);
    check({nm, "_lat"}, n, 32'd8);
    check({nm, "_res"}, {22'd0, busy8, co8, v8, s8},
          {22'd0, 1'b0, t.co, t.v, t.s});
  endtask

  initial begin
    int n;
    int seen;
    logic [3:0] ea, eb, ebb;
    logic       eci, esub, ev;
    logic [4:0] ef;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

    rst8 = 1'b1; st8 = 1'b1; sub8 = 1'b0; ci8 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55;
    rst4 = 1'b1; st4 = 1'b0; sub4 = 1'b0; ci4 = 1'b0;
    a4 = '0; b4 = '0;
    step();
    step();
    check("reset8", {20'd0, busy8, done8, co8, v8, s8}, 32'd0);
    check("reset4", {24'd0, busy4, done4, co4, v4, s4}, 32'd0);
    rst8 = 1'b0; rst4 = 1'b0; st8 = 1'b0;
    step();

    for (int i = 0; i < 10; i++)
      run8(vecs[i], $sformatf("vec%0d", i));

    // start pulsed mid-run is ignored
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; sub8 = 1'b0;
    st8 = 1'b1;
    step();
    st8 = 1'b0;
    step();
    step();
    a8 = 8'hFF; st8 = 1'b1;
    step();
    st8 = 1'b0;
    wait_done8(n);
    check("ign_lat", n + 3, 32'd8);
    check("ign_res", {23'd0, co8, v8, s8}, 32'h030);

    // reset mid-run aborts with no done
    a8 = 8'h10; b8 = 8'h20;
    st8 = 1'b1;
    step();
    st8 = 1'b0;
    step(); step(); step();
    rst8 = 1'b1;
    step();
    check("rst_run", {21'd0, busy8, done8, co8, v8, s8}, 32'd0);
    rst8 = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 || busy8) seen++;
    end
    check("rst_nodone", seen, 32'd0);
    run8('{8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1},
         "after_rst");

    // exhaustive 4-bit, each op started in the previous done cycle
    {sub4, ci4, b4, a4} = 10'd0;
    st4 = 1'b1;
    step();
    for (int i = 0; i < 1024; i++) begin
      st4 = 1'b0;
      n = 0;
      do begin
        step();
        n++;
      end while (!done4 && n < 20);
      ea = 4'(i); eb = 4'(i >> 4);
      eci = 1'(i >> 8); esub = 1'(i >> 9);
      ebb = esub ? ~eb : eb;
      ef = {1'b0, ea} + {1'b0, ebb} + {4'd0, eci};
      ev = (ea[3] == ebb[3]) && (ef[3] != ea[3]);
      check($sformatf("exh%0d", i),
            {22'd0, n[3:0], ef[4], ev, ef[3:0]},
            {22'd0, 4'd2, co4, v4, s4});
      if (i < 1023) begin
        {sub4, ci4, b4, a4} = 10'(i + 1);
        st4 = 1'b1;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
